// File: rtl/mod12_run_scheduler_pkg.sv
// Shared constants, state encoding and payload types for the mod-12 run scheduler.
package mod12_run_scheduler_pkg;

    localparam int unsigned RUN_W = 8;
    localparam int unsigned MOD   = 12;
    localparam int unsigned DW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [DW-1:0]    start;
        logic [RUN_W-1:0] len;
    } run_req_t;

    // Modulo-MOD increment with explicit wrap, mirrors a correct counter
    function automatic logic [DW-1:0] mod_inc(input logic [DW-1:0] v);
        return (v == DW'(MOD - 1)) ? '0 : v + DW'(1);
    endfunction

endpackage

// File: rtl/mod12_run_scheduler_if.sv
// Requester and counter-side signals of the run scheduler.
interface mod12_run_scheduler_if;
    import mod12_run_scheduler_pkg::*;

    logic [1:0]       req;
    logic [DW-1:0]    start0;
    logic [DW-1:0]    start1;
    logic [RUN_W-1:0] len0;
    logic [RUN_W-1:0] len1;
    logic [1:0]       ack;
    logic             done;
    logic [DW-1:0]    result;
    logic             mismatch;
    logic             range_err;
    logic             busy;
    logic             cnt_load;
    logic [DW-1:0]    cnt_din;
    logic [DW-1:0]    cnt_dout;

    modport slave (
        input  req, start0, start1, len0, len1, cnt_dout,
        output ack, done, result, mismatch, range_err, busy, cnt_load, cnt_din
    );

    modport master (
        output req, start0, start1, len0, len1, cnt_dout,
        input  ack, done, result, mismatch, range_err, busy, cnt_load, cnt_din
    );

endinterface

// File: rtl/mod12_run_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter; pointer names the requester favoured on a tie.
module mod12_run_scheduler_rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       advance,
    output logic       grant_c,
    output logic       valid_c
);

    logic       ptr;
    logic [1:0] eligible;

    assign eligible = req & ~mask;

    always_comb begin
        valid_c = |eligible;
        grant_c = 1'b0;
        if (eligible == 2'b11) begin
            grant_c = ptr;
        end else begin
            grant_c = eligible[1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance && valid_c) begin
            ptr <= ~grant_c;
        end
    end

endmodule

// File: rtl/mod12_run_scheduler.sv
// Shares one loadable mod-12 counter between two requesters: preload, run N cycles,
// sample and compare against a shadow count.
module mod12_run_scheduler
    import mod12_run_scheduler_pkg::*;
(
    input  logic clock,
    input  logic reset,
    mod12_run_scheduler_if.slave bus
);

    state_e           state, state_nxt;
    logic             grant_c, valid_c;
    run_req_t         sel_c;
    logic             range_ok_c;

    logic             g, g_nxt;
    run_req_t         cap, cap_nxt;
    logic [DW-1:0]    shadow, shadow_nxt;
    logic [RUN_W-1:0] remaining, remaining_nxt;

    logic [1:0]       ack_nxt;
    logic             done_nxt, mismatch_nxt, range_err_nxt, busy_nxt, cnt_load_nxt;
    logic [DW-1:0]    result_nxt, cnt_din_nxt;

    // A requester whose ack is showing this cycle is masked from arbitration
    mod12_run_scheduler_rr_arbiter2 u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (bus.req),
        .mask    (bus.ack),
        .advance (state == ST_IDLE),
        .grant_c (grant_c),
        .valid_c (valid_c)
    );

    always_comb begin
        sel_c = grant_c ? run_req_t'{start: bus.start1, len: bus.len1}
                        : run_req_t'{start: bus.start0, len: bus.len0};
        range_ok_c = (sel_c.start < DW'(MOD));
    end

    always_comb begin
        state_nxt     = state;
        g_nxt         = g;
        cap_nxt       = cap;
        shadow_nxt    = shadow;
        remaining_nxt = remaining;
        ack_nxt       = 2'b00;
        done_nxt      = 1'b0;
        mismatch_nxt  = 1'b0;
        range_err_nxt = 1'b0;
        result_nxt    = bus.result;
        cnt_din_nxt   = bus.cnt_din;

        case (state)
            ST_IDLE: begin
                if (valid_c) begin
                    g_nxt   = grant_c;
                    cap_nxt = sel_c;
                    if (range_ok_c) begin
                        state_nxt   = ST_LOAD;
                        cnt_din_nxt = sel_c.start;
                    end else begin
                        ack_nxt       = grant_c ? 2'b10 : 2'b01;
                        range_err_nxt = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                shadow_nxt    = cap.start;
                remaining_nxt = cap.len;
                state_nxt     = (cap.len != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                shadow_nxt    = mod_inc(shadow);
                remaining_nxt = remaining - RUN_W'(1);
                if (remaining == RUN_W'(1)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                result_nxt   = bus.cnt_dout;
                mismatch_nxt = (bus.cnt_dout != shadow);
                done_nxt     = 1'b1;
                ack_nxt      = g ? 2'b10 : 2'b01;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt     = (state_nxt != ST_IDLE);
        cnt_load_nxt = (state_nxt == ST_LOAD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            g             <= 1'b0;
            cap           <= '0;
            shadow        <= '0;
            remaining     <= '0;
            bus.ack       <= 2'b00;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.mismatch  <= 1'b0;
            bus.range_err <= 1'b0;
            bus.busy      <= 1'b0;
            bus.cnt_load  <= 1'b0;
            bus.cnt_din   <= '0;
        end else begin
            state         <= state_nxt;
            g             <= g_nxt;
            cap           <= cap_nxt;
            shadow        <= shadow_nxt;
            remaining     <= remaining_nxt;
            bus.ack       <= ack_nxt;
            bus.done      <= done_nxt;
            bus.result    <= result_nxt;
            bus.mismatch  <= mismatch_nxt;
            bus.range_err <= range_err_nxt;
            bus.busy      <= busy_nxt;
            bus.cnt_load  <= cnt_load_nxt;
            bus.cnt_din   <= cnt_din_nxt;
        end
    end

endmodule

// File: tb/tb_mod12_run_scheduler.sv
// Directed bench for mod12_run_scheduler with a behavioural mod-12 counter on the counter port.
module tb_mod12_run_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic skip  = 1'b0;
    logic [3:0] cnt_q = 4'd0;
    int n_vec  = 0;
    int n_miss = 0;

    mod12_run_scheduler_if bus ();

    mod12_run_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Loadable free-running mod-12 counter; skip stalls one increment on demand
    always_ff @(posedge clock) begin
        if (bus.cnt_load)      cnt_q <= bus.cnt_din;
        else if (skip)         cnt_q <= cnt_q;
        else if (cnt_q == 4'd11) cnt_q <= 4'd0;
        else                   cnt_q <= cnt_q + 4'd1;
    end
    assign bus.cnt_dout = cnt_q;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int budget, output int cyc, output int loads, output logic [3:0] din);
        cyc = 0; loads = 0; din = 4'd0;
        while (cyc < budget) begin
            @(negedge clock);
            cyc++;
            if (bus.cnt_load) begin
                loads++;
                din = bus.cnt_din;
            end
            if (bus.ack != 2'b00) break;
        end
        check("ack_seen", 32'(bus.ack != 2'b00), 32'd1);
    endtask

    // Waits for the next ack, checks the completion outputs and drops the acked req bit
    task automatic serve(input string t, input logic [1:0] ack_e, input int cyc_e,
                         input int loads_e, input logic [3:0] din_e, input logic done_e,
                         input logic [3:0] res_e, input logic mis_e, input logic rerr_e);
        int cyc, loads;
        logic [3:0] din;
        wait_ack(60, cyc, loads, din);
        check({t, ".ack"},       32'(bus.ack),       32'(ack_e));
        check({t, ".latency"},   32'(cyc),           32'(cyc_e));
        check({t, ".loads"},     32'(loads),         32'(loads_e));
        if (loads_e != 0) check({t, ".cnt_din"}, 32'(din), 32'(din_e));
        check({t, ".done"},      32'(bus.done),      32'(done_e));
        check({t, ".range_err"}, 32'(bus.range_err), 32'(rerr_e));
        check({t, ".mismatch"},  32'(bus.mismatch),  32'(mis_e));
        if (done_e) check({t, ".result"}, 32'(bus.result), 32'(res_e));
        bus.req = bus.req & ~bus.ack;
    endtask

    task automatic check_idle_outputs(input string t);
        check({t, ".ack"},       32'(bus.ack),       32'd0);
        check({t, ".done"},      32'(bus.done),      32'd0);
        check({t, ".result"},    32'(bus.result),    32'd0);
        check({t, ".mismatch"},  32'(bus.mismatch),  32'd0);
        check({t, ".range_err"}, 32'(bus.range_err), 32'd0);
        check({t, ".busy"},      32'(bus.busy),      32'd0);
        check({t, ".cnt_load"},  32'(bus.cnt_load),  32'd0);
        check({t, ".cnt_din"},   32'(bus.cnt_din),   32'd0);
    endtask

    initial begin
        bus.req = 2'b00;
        bus.start0 = 4'd0; bus.start1 = 4'd0;
        bus.len0 = 8'd0;   bus.len1 = 8'd0;
        repeat (2) @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b1;

        // Single requester 0: 7 + 5 wraps to 0
        @(negedge clock);
        bus.start0 = 4'd7; bus.len0 = 8'd5; bus.req = 2'b01;
        serve("t1", 2'b01, 8, 1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0);

        // Zero-length run goes LOAD then DONE
        bus.start1 = 4'd11; bus.len1 = 8'd0; bus.req = 2'b10;
        serve("t2", 2'b10, 3, 1, 4'd11, 1'b1, 4'd11, 1'b0, 1'b0);

        // Tie with pointer on requester 0, then requester 1 follows straight away
        @(negedge clock);
        bus.start0 = 4'd2; bus.len0 = 8'd3;
        bus.start1 = 4'd4; bus.len1 = 8'd20;
        bus.req = 2'b11;
        serve("t3a", 2'b01, 6, 1, 4'd2, 1'b1, 4'd5, 1'b0, 1'b0);
        serve("t3b", 2'b10, 23, 1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0);

        // Out-of-range start is refused one cycle later without a load
        @(negedge clock);
        bus.start0 = 4'd13; bus.len0 = 8'd5; bus.req = 2'b01;
        serve("t4", 2'b01, 1, 0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);

        // Refused grant still moved the pointer, so requester 1 wins this tie
        @(negedge clock);
        bus.start0 = 4'd1; bus.len0 = 8'd1;
        bus.start1 = 4'd6; bus.len1 = 8'd2;
        bus.req = 2'b11;
        serve("t5a", 2'b10, 5, 1, 4'd6, 1'b1, 4'd8, 1'b0, 1'b0);
        serve("t5b", 2'b01, 4, 1, 4'd1, 1'b1, 4'd2, 1'b0, 1'b0);

        // Counter stalls once mid-run: 3 + 4 - 1 = 6 against shadow 7
        @(negedge clock);
        bus.start0 = 4'd3; bus.len0 = 8'd4; bus.req = 2'b01;
        @(negedge clock);
        check("t6.load_strobe", 32'(bus.cnt_load), 32'd1);
        check("t6.load_value",  32'(bus.cnt_din),  32'd3);
        check("t6.busy_load",   32'(bus.busy),     32'd1);
        @(negedge clock);
        check("t6.load_off",    32'(bus.cnt_load), 32'd0);
        check("t6.busy_run",    32'(bus.busy),     32'd1);
        skip = 1'b1;
        @(negedge clock);
        skip = 1'b0;
        serve("t6", 2'b01, 4, 0, 4'd0, 1'b1, 4'd6, 1'b1, 1'b0);

        // Asynchronous reset during a run aborts without an ack
        @(negedge clock);
        bus.start0 = 4'd5; bus.len0 = 8'd10; bus.req = 2'b01;
        repeat (4) @(negedge clock);
        check("t7.busy_before", 32'(bus.busy), 32'd1);
        #2 reset = 1'b0;
        #1 check_idle_outputs("t7.abort");
        bus.req = 2'b00;
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t7.no_ack", 32'(bus.ack), 32'd0);
        end

        bus.start1 = 4'd1; bus.len1 = 8'd2; bus.req = 2'b10;
        serve("t8", 2'b10, 5, 1, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0);

        // Pointer back on requester 0 after reset and a requester-1 grant
        @(negedge clock);
        bus.start0 = 4'd0; bus.len0 = 8'd0;
        bus.start1 = 4'd9; bus.len1 = 8'd0;
        bus.req = 2'b11;
        serve("t9a", 2'b01, 3, 1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        serve("t9b", 2'b10, 3, 1, 4'd9, 1'b1, 4'd9, 1'b0, 1'b0);

        @(negedge clock);
        check("final.busy", 32'(bus.busy), 32'd0);
        check("final.ack",  32'(bus.ack),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
